// File: rtl/cdc_halt_ctrl.sv
// CPU-side request/halt controller for N handshake channels already synchronised into the CPU clock.
// Define CDC_HALT_CTRL_TIMEOUT_EN to add the wait timer, sticky err_o flags and the ERR_DATA read return.
module cdc_halt_ctrl #(
  parameter int unsigned               NUM_CH         = 4,
  parameter int unsigned               ADDR_W         = 32,
  parameter int unsigned               DATA_W         = 32,
  parameter logic [NUM_CH*ADDR_W-1:0]  CH_START       = '0,
  parameter logic [NUM_CH*ADDR_W-1:0]  CH_END         = '0,
  parameter logic [NUM_CH-1:0]         BUSY_EN_MASK   = '1,
  parameter int unsigned               TIMEOUT_CYCLES = 256,
  parameter logic [DATA_W-1:0]         ERR_DATA       = DATA_W'(32'hDEAD_BEEF)
) (
  input  logic                     clk_i,
  input  logic                     reset_ni,
  input  logic [ADDR_W-1:0]        address_i,
  input  logic [DATA_W-1:0]        data_i,
  input  logic                     strobe_i,
  input  logic                     we_i,
  output logic [NUM_CH-1:0]        ch_req_o,
  output logic                     ch_we_o,
  output logic [ADDR_W-1:0]        ch_addr_o,
  output logic [DATA_W-1:0]        ch_data_o,
  input  logic [NUM_CH-1:0]        ch_ack_i,
  input  logic [NUM_CH*DATA_W-1:0] ch_rdata_i,
  output logic                     cpu_halt_o,
  output logic [DATA_W-1:0]        rdata_o,
  output logic                     rvalid_o,
  output logic [NUM_CH-1:0]        err_o,
  input  logic [NUM_CH-1:0]        clr_err_i
);

  localparam int unsigned SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [NUM_CH-1:0]   req_q, req_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                rvalid_q, rvalid_d;
  logic [NUM_CH-1:0]   err_set_c;

  logic                hit_any_c;
  logic [SEL_W-1:0]    sel_c;
  logic                hs_c;
  logic                ack_c;
  logic                tmo_c;
  logic [DATA_W-1:0]   rdata_sel_c;

  // Address decode: lowest-index channel whose inclusive range contains the address.
  always_comb begin
    hit_any_c = 1'b0;
    sel_c     = '0;
    for (int k = 0; k < int'(NUM_CH); k++) begin
      if (!hit_any_c &&
          address_i >= CH_START[k*ADDR_W +: ADDR_W] &&
          address_i <= CH_END[k*ADDR_W +: ADDR_W]) begin
        hit_any_c = 1'b1;
        sel_c     = SEL_W'(k);
      end
    end
  end

  assign hs_c = strobe_i && hit_any_c && BUSY_EN_MASK[sel_c];

  // Ack and read data of the latched channel only; other channels are ignored.
  always_comb begin
    ack_c       = 1'b0;
    rdata_sel_c = '0;
    for (int k = 0; k < int'(NUM_CH); k++) begin
      if (sel_q == SEL_W'(k)) begin
        ack_c       = ch_ack_i[k];
        rdata_sel_c = ch_rdata_i[k*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q  <= ST_IDLE;
      sel_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      req_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      req_q    <= req_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (hs_c) state_d = ST_REQ;
      ST_REQ:  state_d = ST_WAIT;
      ST_WAIT: if (ack_c || tmo_c) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Request is registered on acceptance so it is high exactly during REQ; ack beats timeout.
  always_comb begin
    sel_d     = sel_q;
    we_d      = we_q;
    addr_d    = addr_q;
    data_d    = data_q;
    req_d     = '0;
    rdata_d   = rdata_q;
    rvalid_d  = 1'b0;
    err_set_c = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (hs_c) begin
          sel_d  = sel_c;
          we_d   = we_i;
          addr_d = address_i;
          data_d = data_i;
          req_d  = NUM_CH'(1) << sel_c;
        end
      end
      ST_WAIT: begin
        if (ack_c) begin
          rvalid_d = 1'b1;
          if (!we_q) rdata_d = rdata_sel_c;
        end else if (tmo_c) begin
          rvalid_d  = 1'b1;
          err_set_c = NUM_CH'(1) << sel_q;
          if (!we_q) rdata_d = ERR_DATA;
        end
      end
      default: ;
    endcase
  end

`ifdef CDC_HALT_CTRL_TIMEOUT_EN
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [NUM_CH-1:0] err_q, err_d;

  // Saturating wait timer, cleared while the request is on the bus; set beats clear.
  always_comb begin
    timer_d = timer_q;
    if (state_q == ST_REQ) begin
      timer_d = '0;
    end else if (state_q == ST_WAIT && timer_q != '1) begin
      timer_d = timer_q + TMR_W'(1);
    end
    err_d = (err_q & ~clr_err_i) | err_set_c;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      timer_q <= '0;
      err_q   <= '0;
    end else begin
      timer_q <= timer_d;
      err_q   <= err_d;
    end
  end

  assign tmo_c = (state_q == ST_WAIT) && (timer_q == TMR_W'(TIMEOUT_CYCLES - 1));
  assign err_o = err_q;
`else
  logic unused_tmo;
  assign unused_tmo = ^{clr_err_i, err_set_c};
  assign tmo_c      = 1'b0;
  assign err_o      = '0;
`endif

  assign ch_req_o   = req_q;
  assign ch_we_o    = we_q;
  assign ch_addr_o  = addr_q;
  assign ch_data_o  = data_q;
  assign rdata_o    = rdata_q;
  assign rvalid_o   = rvalid_q;
  assign cpu_halt_o = hs_c || (state_q != ST_IDLE);

endmodule
